alarm_unit: RTL and testbench

Alarm register and trigger stage, directly downstream of the four-key controller.
- Consumes the controller's alarm-adjust outputs: adjust_alarm, flip_state, select_add, alarm_add, alarm_clr.
- Holds an HH:MM alarm time as four BCD digits, plus an enable flag and the selected-digit index.
- Compares the stored alarm against the running clock and drives a timed ringing output toward the buzzer/LED and display stages.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_ring_timer.sv | 39 +++
 rtl/alarm_unit.sv | 127 ++++++++++++
 tb/tb_alarm_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared constants and helpers for the alarm unit
package alarm_pkg;

    // Digit positions within the HH:MM alarm word {Ht,Hu,Mt,Mu}
    localparam logic [1:0] DIG_HT = 2'd0;
    localparam logic [1:0] DIG_HU = 2'd1;
    localparam logic [1:0] DIG_MT = 2'd2;
    localparam logic [1:0] DIG_MU = 2'd3;

    // Upper limit of each digit; Hu drops to 3 when Ht is 2
    localparam logic [3:0] LIM_HT    = 4'd2;
    localparam logic [3:0] LIM_HU    = 4'd9;
    localparam logic [3:0] LIM_HU_20 = 4'd3;
    localparam logic [3:0] LIM_MT    = 4'd5;
    localparam logic [3:0] LIM_MU    = 4'd9;

    localparam logic [15:0] DEFAULT_RESET_ALARM = 16'h0700;

    // Ring counter holds up to 255 seconds
    localparam int RING_CNT_W = 8;

    // Increment a BCD digit, wrapping to 0 once it passes its limit
    function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_ring_timer.sv
// rtl/alarm_ring_timer.sv - timed ringing output with stop/disable override
module alarm_ring_timer
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS = 60
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic trigger,
    input  logic stop,
    input  logic disable_ring,
    input  logic sec_tick,
    output logic ringing
);

    localparam logic [RING_CNT_W-1:0] RING_LOAD = RING_CNT_W'(RING_SECONDS);

    logic [RING_CNT_W-1:0] count;

    // Stop/disable beat trigger, trigger beats the tick; the tick reaching 0 ends the ring
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            ringing <= 1'b0;
        end else if (stop || disable_ring) begin
            count   <= '0;
            ringing <= 1'b0;
        end else if (trigger) begin
            count   <= RING_LOAD;
            ringing <= 1'b1;
        end else if (ringing && sec_tick) begin
            count <= count - 1'b1;
            if (count == {{(RING_CNT_W-1){1'b0}}, 1'b1}) begin
                ringing <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - alarm time editing, clock match and ring trigger
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int          RING_SECONDS = 60,
    parameter logic [15:0] RESET_ALARM  = DEFAULT_RESET_ALARM
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        adjust_alarm,
    input  logic        flip_state,
    input  logic        select_add,
    input  logic        alarm_add,
    input  logic        alarm_clr,
    input  logic        stop_ring,
    input  logic        sec_tick,
    input  logic [15:0] time_hhmm,
    input  logic [7:0]  time_ss,
    output logic [15:0] alarm_time,
    output logic        alarm_en,
    output logic [1:0]  sel_digit,
    output logic        ringing
);

    logic flip_q, select_q, add_q, clr_q, stop_q, adjust_q, match_q;
    logic flip_ev, select_ev, add_ev, clr_ev, stop_ev, adjust_rise;
    logic match, trigger, disable_ring;
    logic [15:0] next_time;
    logic [3:0]  ht_n;

    // One-flop histories turn each level into a single-cycle event
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            flip_q   <= 1'b0;
            select_q <= 1'b0;
            add_q    <= 1'b0;
            clr_q    <= 1'b0;
            stop_q   <= 1'b0;
            adjust_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            flip_q   <= flip_state;
            select_q <= select_add;
            add_q    <= alarm_add;
            clr_q    <= alarm_clr;
            stop_q   <= stop_ring;
            adjust_q <= adjust_alarm;
            match_q  <= match;
        end
    end

    // Event decode and alarm match against the running clock
    always_comb begin
        flip_ev      = flip_state & ~flip_q;
        select_ev    = select_add & ~select_q;
        add_ev       = alarm_add & ~add_q;
        clr_ev       = alarm_clr & ~clr_q;
        stop_ev      = stop_ring & ~stop_q;
        adjust_rise  = adjust_alarm & ~adjust_q;
        match        = alarm_en & ~adjust_alarm & (time_hhmm == alarm_time) & (time_ss == 8'h00);
        trigger      = match & ~match_q;
        // Toggling from armed to disarmed silences any ring in progress
        disable_ring = adjust_alarm & flip_ev & alarm_en;
    end

    // Next alarm digits: clear beats increment, both act on the current selection
    always_comb begin
        next_time = alarm_time;
        ht_n      = bump(alarm_time[15:12], LIM_HT);
        if (adjust_alarm) begin
            if (clr_ev) begin
                case (sel_digit)
                    DIG_HT:  next_time[15:12] = 4'd0;
                    DIG_HU:  next_time[11:8]  = 4'd0;
                    DIG_MT:  next_time[7:4]   = 4'd0;
                    default: next_time[3:0]   = 4'd0;
                endcase
            end else if (add_ev) begin
                case (sel_digit)
                    DIG_HT: begin
                        next_time[15:12] = ht_n;
                        // Entering the 20s must not leave an hour above 23
                        if (ht_n == 4'd2 && alarm_time[11:8] > LIM_HU_20) begin
                            next_time[11:8] = LIM_HU_20;
                        end
                    end
                    DIG_HU: next_time[11:8] = bump(alarm_time[11:8],
                                (alarm_time[15:12] == 4'd2) ? LIM_HU_20 : LIM_HU);
                    DIG_MT: next_time[7:4] = bump(alarm_time[7:4], LIM_MT);
                    default: next_time[3:0] = bump(alarm_time[3:0], LIM_MU);
                endcase
            end
        end
    end

    // Alarm registers: digits, armed flag and digit selection
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            alarm_time <= RESET_ALARM;
            alarm_en   <= 1'b0;
            sel_digit  <= DIG_HT;
        end else begin
            alarm_time <= next_time;
            if (adjust_alarm && flip_ev) begin
                alarm_en <= ~alarm_en;
            end
            if (adjust_rise) begin
                sel_digit <= DIG_HT;
            end else if (adjust_alarm && select_ev) begin
                sel_digit <= sel_digit + 2'd1;
            end
        end
    end

    alarm_ring_timer #(
        .RING_SECONDS (RING_SECONDS)
    ) u_ring_timer (
        .CLOCK_50     (CLOCK_50),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .stop         (stop_ev | adjust_rise),
        .disable_ring (disable_ring),
        .sec_tick     (sec_tick),
        .ringing      (ringing)
    );

endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - table, directed and randomized checks of alarm_unit
module tb_alarm_unit;

    localparam int RING = 3;

    logic        CLOCK_50, rst_n;
    logic        adjust_alarm, flip_state, select_add, alarm_add, alarm_clr, stop_ring, sec_tick;
    logic [15:0] time_hhmm;
    logic [7:0]  time_ss;
    logic [15:0] alarm_time;
    logic        alarm_en, ringing;
    logic [1:0]  sel_digit;

    int errors = 0;
    int checks = 0;

    alarm_unit #(.RING_SECONDS(RING), .RESET_ALARM(16'h0700)) dut (
        .CLOCK_50     (CLOCK_50),
        .rst_n        (rst_n),
        .adjust_alarm (adjust_alarm),
        .flip_state   (flip_state),
        .select_add   (select_add),
        .alarm_add    (alarm_add),
        .alarm_clr    (alarm_clr),
        .stop_ring    (stop_ring),
        .sec_tick     (sec_tick),
        .time_hhmm    (time_hhmm),
        .time_ss      (time_ss),
        .alarm_time   (alarm_time),
        .alarm_en     (alarm_en),
        .sel_digit    (sel_digit),
        .ringing      (ringing)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: digits as integers, ring as seconds remaining
    int md[4];
    bit men;
    int msel;
    int mleft;
    bit p_flip, p_sel, p_add, p_clr, p_stop, p_adj, p_match;

    function automatic logic [15:0] mtime();
        return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
    endfunction

    task automatic model_reset();
        md[0] = 0; md[1] = 7; md[2] = 0; md[3] = 0;
        men = 0; msel = 0; mleft = 0;
        {p_flip, p_sel, p_add, p_clr, p_stop, p_adj, p_match} = '0;
    endtask

    task automatic model_step();
        bit fe, se, ae, ce, ste, are, m, kill;
        int s;
        fe  = flip_state & !p_flip;
        se  = select_add & !p_sel;
        ae  = alarm_add & !p_add;
        ce  = alarm_clr & !p_clr;
        ste = stop_ring & !p_stop;
        are = adjust_alarm & !p_adj;
        m   = men && !adjust_alarm && time_hhmm == mtime() && time_ss == 8'h00;
        kill = ste || are;
        s = msel;
        if (adjust_alarm) begin
            if (ce) md[s] = 0;
            else if (ae) begin
                case (s)
                    0: begin
                        md[0] = (md[0] + 1) % 3;
                        if (md[0] == 2 && md[1] > 3) md[1] = 3;
                    end
                    1: md[1] = (md[1] + 1) % ((md[0] == 2) ? 4 : 10);
                    2: md[2] = (md[2] + 1) % 6;
                    default: md[3] = (md[3] + 1) % 10;
                endcase
            end
            if (se) msel = (msel + 1) % 4;
            if (fe) begin
                men = !men;
                if (!men) kill = 1;
            end
        end
        if (are) msel = 0;
        if (kill) mleft = 0;
        else if (m && !p_match) mleft = RING;
        else if (mleft > 0 && sec_tick) mleft = mleft - 1;
        p_flip = flip_state; p_sel = select_add; p_add = alarm_add;
        p_clr = alarm_clr; p_stop = stop_ring; p_adj = adjust_alarm; p_match = m;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_pulses();
        flip_state = 0; select_add = 0; alarm_add = 0; alarm_clr = 0; stop_ring = 0; sec_tick = 0;
    endtask

    // which: 0 flip, 1 select, 2 add, 3 clr, 4 stop, 5 tick
    task automatic pulse(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            case (which)
                0: flip_state = 1;
                1: select_add = 1;
                2: alarm_add  = 1;
                3: alarm_clr  = 1;
                4: stop_ring  = 1;
                default: sec_tick = 1;
            endcase
            cycle();
            clear_pulses();
            cycle();
        end
    endtask

    typedef struct {
        logic        adj, flip, sel, add, clr;
        logic [15:0] exp_time;
        logic        exp_en;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic adj, flip, sel, add, clr,
                                input logic [15:0] t, input logic en, input logic [1:0] sd);
        vec_t v;
        v.adj = adj; v.flip = flip; v.sel = sel; v.add = add; v.clr = clr;
        v.exp_time = t; v.exp_en = en; v.exp_sel = sd;
        return v;
    endfunction

    task automatic check_ring_seq(input string tag);
        time_ss = 8'h01; cycle();
        time_ss = 8'h00; cycle();
        check({tag, "_ring_on"}, 16'(ringing), 16'd1);
    endtask

    initial begin
        rst_n = 0; adjust_alarm = 0; clear_pulses();
        time_hhmm = 16'h0000; time_ss = 8'h01;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_time", alarm_time, 16'h0700);
        check("rst_en", 16'(alarm_en), 16'd0);
        check("rst_sel", 16'(sel_digit), 16'd0);
        check("rst_ring", 16'(ringing), 16'd0);
        rst_n = 1;

        //              adj flip sel add clr  time     en sel
        tbl[0]  = mk(0, 0, 0, 1, 0, 16'h0700, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 16'h0700, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 16'h0700, 0, 0);
        tbl[3]  = mk(1, 0, 0, 1, 0, 16'h1700, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 16'h1700, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 0, 16'h2300, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 16'h2300, 0, 0);
        tbl[7]  = mk(1, 0, 0, 1, 0, 16'h0300, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 16'h0300, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 16'h0300, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 16'h0300, 1, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 0);
        tbl[12] = mk(1, 0, 1, 0, 0, 16'h0300, 1, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 1);
        tbl[14] = mk(1, 0, 1, 0, 0, 16'h0300, 1, 2);
        tbl[15] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 2);
        tbl[16] = mk(1, 0, 1, 0, 0, 16'h0300, 1, 3);
        tbl[17] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 3);
        tbl[18] = mk(1, 0, 1, 0, 0, 16'h0300, 1, 0);
        tbl[19] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 0);
        tbl[20] = mk(1, 0, 1, 0, 0, 16'h0300, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 1);
        tbl[22] = mk(0, 1, 1, 0, 0, 16'h0300, 1, 1);
        tbl[23] = mk(1, 0, 0, 0, 0, 16'h0300, 1, 0);

        for (int i = 0; i < 24; i++) begin
            adjust_alarm = tbl[i].adj; flip_state = tbl[i].flip; select_add = tbl[i].sel;
            alarm_add = tbl[i].add; alarm_clr = tbl[i].clr;
            cycle();
            check($sformatf("tbl%0d_time", i), alarm_time, tbl[i].exp_time);
            check($sformatf("tbl%0d_en", i), 16'(alarm_en), 16'(tbl[i].exp_en));
            check($sformatf("tbl%0d_sel", i), 16'(sel_digit), 16'(tbl[i].exp_sel));
        end
        clear_pulses();

        // Held add yields exactly one increment on Hu
        pulse(1, 1);
        alarm_add = 1;
        repeat (20) cycle();
        check("held_add", alarm_time, 16'h0400);
        clear_pulses(); cycle();

        // Build 07:59 on Mu, then wrap and clear-beats-add
        pulse(2, 3);
        pulse(1, 1); pulse(2, 5);
        pulse(1, 1); pulse(2, 9);
        check("set_0759", alarm_time, 16'h0759);
        check("sel_mu", 16'(sel_digit), 16'd3);
        pulse(2, 1);
        check("mu_wrap", alarm_time, 16'h0750);
        pulse(2, 1);
        check("mu_inc", alarm_time, 16'h0751);
        alarm_clr = 1; alarm_add = 1; cycle(); clear_pulses();
        check("clr_beats_add", alarm_time, 16'h0750);
        cycle();

        // Back to 07:00 and ring
        pulse(1, 3);
        pulse(3, 1);
        check("clr_mt", alarm_time, 16'h0700);
        adjust_alarm = 0; time_hhmm = 16'h0700; time_ss = 8'h01; cycle();
        check("no_ring_ss01", 16'(ringing), 16'd0);
        time_ss = 8'h00; cycle();
        check("ring_start", 16'(ringing), 16'd1);
        for (int k = 1; k <= RING; k++) begin
            pulse(5, 1);
            check($sformatf("ring_tick%0d", k), 16'(ringing), (k < RING) ? 16'd1 : 16'd0);
        end
        repeat (5) cycle();
        check("no_retrigger", 16'(ringing), 16'd0);

        check_ring_seq("stop");
        stop_ring = 1; cycle();
        check("stop_clears", 16'(ringing), 16'd0);
        clear_pulses(); cycle();

        time_ss = 8'h01; cycle();
        time_ss = 8'h00; stop_ring = 1; cycle();
        check("stop_beats_trig", 16'(ringing), 16'd0);
        clear_pulses(); cycle();

        check_ring_seq("flip");
        adjust_alarm = 1; flip_state = 1; cycle();
        check("flip_clears", 16'(ringing), 16'd0);
        check("flip_disarm", 16'(alarm_en), 16'd0);
        clear_pulses(); cycle();
        pulse(0, 1);
        check("flip_rearm", 16'(alarm_en), 16'd1);
        adjust_alarm = 0; cycle();

        check_ring_seq("rst");
        rst_n = 0; #1;
        check("rst_ring_async", 16'(ringing), 16'd0);
        check("rst_time_async", alarm_time, 16'h0700);
        check("rst_en_async", 16'(alarm_en), 16'd0);
        model_reset();
        adjust_alarm = 0; clear_pulses(); time_ss = 8'h01;
        @(posedge CLOCK_50); #1;
        rst_n = 1;

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 29) == 0) adjust_alarm = ~adjust_alarm;
            flip_state = ($urandom_range(0, 7) == 0);
            select_add = ($urandom_range(0, 5) == 0);
            alarm_add  = ($urandom_range(0, 3) == 0);
            alarm_clr  = ($urandom_range(0, 9) == 0);
            stop_ring  = ($urandom_range(0, 40) == 0);
            sec_tick   = ($urandom_range(0, 2) == 0);
            time_hhmm  = ($urandom_range(0, 2) != 0) ? mtime() : 16'($urandom);
            time_ss    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            cycle();
            check("rnd_time", alarm_time, mtime());
            check("rnd_en", 16'(alarm_en), 16'(men));
            check("rnd_sel", 16'(sel_digit), 16'(msel));
            check("rnd_ring", 16'(ringing), 16'(mleft > 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
